// File: rtl/uart_pkg.sv
// Shared types and constants for the oversampling UART receiver and its
// future transmitter sibling.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  localparam int OSR      = 16;
  localparam int SAMP_LO  = 6;
  localparam int SAMP_HI  = 11;
  localparam int VOTE_THR = 4;

  // A 3:3 split falls below the threshold, so ties resolve to 0.
  function automatic logic vote_bit(input logic [2:0] ones);
    return ones >= 3'(VOTE_THR);
  endfunction

endpackage

// File: rtl/uart_rx_frame_if.sv
// Serial line, baud divisor and received-frame result bundle.
// slave = receiver side, master = pin driver / protocol layer side.
interface uart_rx_frame_if #(
  parameter int DATA_BITS = 8,
  parameter int DIV_W     = 16
);
  logic                 uart_rx;
  logic [DIV_W-1:0]     baud_div;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 parity_err;
  logic                 frame_err;
  logic                 rx_busy;

  modport slave (
    input  uart_rx, baud_div,
    output rx_data, rx_valid, parity_err, frame_err, rx_busy
  );

  modport master (
    output uart_rx, baud_div,
    input  rx_data, rx_valid, parity_err, frame_err, rx_busy
  );
endinterface

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: counts 0..baud_div and pulses at terminal count.
// Held at zero while disabled so the first tick lands baud_div+1 clocks later.
module uart_baud_tick #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [DIV_W-1:0] baud_div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;
  logic             tc;

  assign tc   = (cnt == baud_div);
  assign tick = enable && tc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!enable || tc) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx_frame.sv
// Parametrised 16x-oversampling UART receiver with majority vote,
// false-start rejection and parity/framing error reporting.
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1,
  parameter int DIV_W      = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  uart_rx_frame_if.slave  bus
);

  // state   | meaning
  // IDLE    | line idle, waiting for a falling edge
  // START   | validating the start bit (false-start check at sample 15)
  // DATA    | shifting in DATA_BITS voted bits, LSB first
  // PARITY  | checking the optional parity bit
  // STOP    | voting stop bit(s); final one ends at sample 11

  localparam logic [3:0] LAST_BIT  = 4'(DATA_BITS - 1);
  localparam logic [3:0] SAMP_END  = 4'(OSR - 1);
  localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

  rx_state_t state_q, state_d;

  logic                 sync1, sync2, line_prev;
  logic                 fall;
  logic [DIV_W-1:0]     div_q;
  logic                 tick;
  logic [3:0]           samp_cnt;
  logic [2:0]           ones;
  logic [2:0]           ones_upd;
  logic                 in_win;
  logic                 bit_val;
  logic                 bit_end;
  logic [3:0]           bit_cnt;
  logic [0:0]           stop_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 exp_par;
  logic                 perr_acc, ferr_acc;
  logic [DATA_BITS-1:0] rx_data_q;
  logic                 rx_valid_q, perr_q, ferr_q;

  logic                 shift_en, par_en, stop_end, done;

  assign fall     = line_prev && !sync2;
  assign in_win   = (samp_cnt >= 4'(SAMP_LO)) && (samp_cnt <= 4'(SAMP_HI));
  // Include the current sample so a vote can be taken on the sample-11 tick.
  assign ones_upd = ones + {2'b00, in_win & sync2};
  assign bit_val  = vote_bit(ones_upd);
  assign bit_end  = tick && (samp_cnt == SAMP_END);
  assign exp_par  = (^shreg) ^ 1'(PARITY_ODD);

  uart_baud_tick #(.DIV_W(DIV_W)) u_baud_tick (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (state_q != IDLE),
    .baud_div (div_q),
    .tick     (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    shift_en = 1'b0;
    par_en   = 1'b0;
    stop_end = 1'b0;
    done     = 1'b0;
    case (state_q)
      IDLE: begin
        if (fall) state_d = START;
      end
      START: begin
        if (bit_end) state_d = bit_val ? IDLE : DATA;
      end
      DATA: begin
        shift_en = bit_end;
        if (bit_end && (bit_cnt == LAST_BIT)) begin
          state_d = (PARITY_EN != 0) ? PARITY : STOP;
        end
      end
      PARITY: begin
        par_en = bit_end;
        if (bit_end) state_d = STOP;
      end
      STOP: begin
        if (stop_cnt == LAST_STOP) begin
          stop_end = tick && (samp_cnt == 4'(SAMP_HI));
          done     = stop_end;
          if (stop_end) state_d = IDLE;
        end else begin
          stop_end = bit_end;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1      <= 1'b1;
      sync2      <= 1'b1;
      line_prev  <= 1'b1;
      div_q      <= '0;
      samp_cnt   <= '0;
      ones       <= '0;
      bit_cnt    <= '0;
      stop_cnt   <= '0;
      shreg      <= '0;
      perr_acc   <= 1'b0;
      ferr_acc   <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      sync1      <= bus.uart_rx;
      sync2      <= sync1;
      line_prev  <= sync2;
      rx_valid_q <= done;

      if (state_q == IDLE) begin
        samp_cnt <= '0;
        ones     <= '0;
        bit_cnt  <= '0;
        stop_cnt <= '0;
        perr_acc <= 1'b0;
        ferr_acc <= 1'b0;
        if (fall) div_q <= bus.baud_div;
      end else if (tick) begin
        samp_cnt <= samp_cnt + 4'd1;
        ones     <= (samp_cnt == 4'd0) ? 3'd0 : ones_upd;
      end

      if (shift_en) begin
        shreg   <= {bit_val, shreg[DATA_BITS-1:1]};
        bit_cnt <= bit_cnt + 4'd1;
      end
      if (par_en) begin
        perr_acc <= (bit_val != exp_par);
      end
      if (stop_end) begin
        ferr_acc <= ferr_acc | ~bit_val;
        stop_cnt <= stop_cnt + 1'b1;
      end
      if (done) begin
        rx_data_q <= shreg;
        perr_q    <= perr_acc;
        ferr_q    <= ferr_acc | ~bit_val;
      end
    end
  end

  assign bus.rx_data    = rx_data_q;
  assign bus.rx_valid   = rx_valid_q;
  assign bus.parity_err = perr_q;
  assign bus.frame_err  = ferr_q;
  assign bus.rx_busy    = (state_q != IDLE);

endmodule
